// File: rtl/fetch_unit.sv
// Fetch front end: credit-limited word fetch from imem into a FQ_DEPTH-entry queue feeding decode.
// Response to inst_valid takes 1 cycle; decode stalls throttle new requests through credits, responses are never stalled.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = CW + 2;

    if (FQ_DEPTH < 2 || (FQ_DEPTH & (FQ_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_unit: FQ_DEPTH must be a power of two and at least 2");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch_unit: RESET_PC must be word aligned");
    end

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
        logic        fault;
    } fq_entry_t;

    fq_entry_t     fq_mem [FQ_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;

    logic [SW-1:0] in_use;
    logic          req_fire;
    logic          rsp_keep;
    logic          rsp_drop;
    logic          pop;
    logic [31:0]   redirect_aligned;
    logic          unused_pc_bits;

    // Every accepted or dropped-pending request reserves a queue slot until it is resolved.
    assign in_use           = SW'(outstanding) + SW'(drop_cnt) + SW'(count);
    assign imem_req_valid   = !rst && !redirect_valid && (in_use < SW'(FQ_DEPTH));
    assign imem_req_addr    = fetch_pc;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign rsp_drop         = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_keep         = imem_rsp_valid && (drop_cnt == '0);
    assign pop              = inst_valid && inst_ready;
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign unused_pc_bits   = ^redirect_pc[1:0];

    assign inst_valid = (count != '0);
    assign inst       = fq_mem[rd_ptr].word;
    assign inst_pc    = fq_mem[rd_ptr].pc;
    assign inst_fault = fq_mem[rd_ptr].fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // A response arriving now retires one of the in-flight requests as a drop.
            fetch_pc    <= redirect_aligned;
            rsp_pc      <= redirect_aligned;
            drop_cnt    <= drop_cnt + outstanding - CW'(imem_rsp_valid);
            outstanding <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (rsp_keep) begin
                rsp_pc <= rsp_pc + 32'd4;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
            count       <= count + CW'(rsp_keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_mem[i] <= '0;
            end
        end else if (rsp_keep && !redirect_valid) begin
            fq_mem[wr_ptr] <= '{word: imem_rsp_data, pc: rsp_pc, fault: imem_rsp_err};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid) begin
            assert (!(rsp_keep && !pop && count == CW'(FQ_DEPTH)));
            assert (!(imem_rsp_valid && outstanding == '0 && drop_cnt == '0));
        end
    end
endmodule
